// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control FSM for a multi-cycle MIPS-subset core. Each instruction steps
// through FETCH -> DECODE -> EXEC -> MEM -> WB, skipping the states it does
// not need. The FSM drives the datapath enables, ALU selection and the
// immediate-extender mode. It handshakes with the shared instruction/data
// memory port and counts retired instructions.
//
// Parameters
//   CNT_W       width of the retired-instruction counter
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   op, funct   IR[31:26] and IR[5:0] (stable from DECODE onward)
//   zero        ALU zero flag (BEQ resolution in EXEC)
//   mem_ack     memory transfer complete this cycle
//   mem_req     memory access request (FETCH and MEM)
//   mem_wr      request is a write (SW in MEM)
//   iord        memory address source: 0 = PC, 1 = ALU result
//   ir_we       load instruction register
//   mdr_we      load memory data register
//   pc_we       load PC
//   pc_src      PC source: 0 = PC+4, 1 = branch target, 2 = jump target
//   reg_we      register file write
//   reg_dst     destination register: 0 = rt, 1 = rd
//   mem_to_reg  write-back data: 0 = ALU result, 1 = MDR
//   alu_src     ALU B operand: 0 = rt, 1 = extended immediate
//   alu_op      0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT
//   ext_arith   extender mode: 1 = sign-extend, 0 = zero-extend
//   illegal     one-cycle pulse in DECODE on an unsupported instruction
//   state       current FSM state (debug)
//   retired     count of completed instructions, wraps
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_wr,
  output logic             iord,
  output logic             ir_we,
  output logic             mdr_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic             ext_arith,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;

  // Instruction class decode
  logic is_r, r_ok, is_alui, is_lw, is_sw, is_beq, is_j, legal;
  logic [2:0] r_alu, i_alu;

  function automatic logic [2:0] funct_to_alu(input logic [5:0] f);
    case (f)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic [2:0] iop_to_alu(input logic [5:0] o);
    case (o)
      OP_SLTI: return ALU_SLT;
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

  always_comb begin
    is_r    = (op == OP_RTYPE);
    r_ok    = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
              (funct == FN_OR)  || (funct == FN_SLT);
    is_alui = (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI) ||
              (op == OP_ANDI) || (op == OP_ORI);
    is_lw   = (op == OP_LW);
    is_sw   = (op == OP_SW);
    is_beq  = (op == OP_BEQ);
    is_j    = (op == OP_J);
    legal   = (is_r && r_ok) || is_alui || is_lw || is_sw || is_beq || is_j;
    r_alu   = funct_to_alu(funct);
    i_alu   = iop_to_alu(op);
  end

  // Logical immediates (ANDI/ORI) zero-extend; everything else that uses the
  // immediate sign-extends. Purely opcode-driven, independent of state.
  assign ext_arith = (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI) ||
                     is_lw || is_sw || is_beq;

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  assign state     = state_q;
  assign retired   = retired_q;

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    mdr_we     = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'd0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        // Held quiet during reset so the memory slave sees no request until
        // rst falls.
        if (!rst) begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = S_DECODE;
          end
        end
      end

      S_DECODE: begin
        if (!legal) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end else if (is_j) begin
          pc_we   = 1'b1;
          pc_src  = 2'd2;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (is_r) begin
          alu_op  = r_alu;
          state_d = S_WB;
        end else if (is_alui) begin
          alu_src = 1'b1;
          alu_op  = i_alu;
          state_d = S_WB;
        end else if (is_lw || is_sw) begin
          alu_src = 1'b1;
          state_d = S_MEM;
        end else begin
          // BEQ: ALU computes rs - rt; taken when the difference is zero.
          alu_op  = ALU_SUB;
          if (zero) begin
            pc_we  = 1'b1;
            pc_src = 2'd1;
          end
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_wr  = is_sw;
        if (mem_ack) begin
          if (is_lw) begin
            mdr_we  = 1'b1;
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end

      S_WB: begin
        reg_we     = 1'b1;
        reg_dst    = is_r;
        mem_to_reg = is_lw;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      // Unused codes recover to FETCH without counting an instruction.
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    op, funct;
  logic          zero, mem_ack;
  logic          mem_req, mem_wr, iord, ir_we, mdr_we, pc_we;
  logic [1:0]    pc_src;
  logic          reg_we, reg_dst, mem_to_reg, alu_src;
  logic [2:0]    alu_op;
  logic          ext_arith, illegal;
  logic [2:0]    state;
  logic [CW-1:0] retired;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_wr(mem_wr), .iord(iord),
    .ir_we(ir_we), .mdr_we(mdr_we), .pc_we(pc_we), .pc_src(pc_src),
    .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .alu_op(alu_op), .ext_arith(ext_arith),
    .illegal(illegal), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    st;
    logic          req, wr, iord, irwe, mdrwe, pcwe;
    logic [1:0]    pcsrc;
    logic          regwe, regdst, m2r, alusrc;
    logic [2:0]    aluop;
    logic          ext, ill;
    logic [CW-1:0] ret;
  } exp_t;

  typedef enum int { K_R, K_ALUI, K_LW, K_SW, K_BEQ, K_J, K_ILL } kind_t;

  exp_t          expq[$];
  string         nameq[$];
  logic          ackq[$];
  int            total = 0;
  int            bad   = 0;
  logic [CW-1:0] cnt;       // expected retired count
  logic          cur_ext;   // expected extender mode for current opcode

  function automatic exp_t blank(input logic [2:0] st);
    exp_t e;
    e     = '0;
    e.st  = st;
    e.ext = cur_ext;
    e.ret = cnt;
    return e;
  endfunction

  task automatic push(input string nm, input exp_t e, input logic ack);
    expq.push_back(e);
    nameq.push_back(nm);
    ackq.push_back(ack);
  endtask

  task automatic step_all();
    while (ackq.size() > 0) begin
      mem_ack = ackq.pop_front();
      @(posedge clk); #1;
    end
  endtask

  // Pushes the hand-derived cycle-by-cycle trace of one instruction, then
  // drives mem_ack for each of those cycles.
  task automatic run_instr(input string nm, input logic [5:0] o, input logic [5:0] f,
                           input kind_t k, input logic [2:0] aop, input logic ext,
                           input logic z, input int fwait, input int mwait);
    exp_t e;
    op = o; funct = f; zero = z; cur_ext = ext;
    for (int i = 0; i < fwait; i++) begin
      e = blank(3'd0); e.req = 1'b1; push({nm, ".fetchwait"}, e, 1'b0);
    end
    e = blank(3'd0); e.req = 1'b1; e.irwe = 1'b1; e.pcwe = 1'b1;
    push({nm, ".fetch"}, e, 1'b1);
    e = blank(3'd1);
    if (k == K_J)   begin e.pcwe = 1'b1; e.pcsrc = 2'd2; end
    if (k == K_ILL) e.ill = 1'b1;
    push({nm, ".decode"}, e, 1'b1);
    if (k != K_J && k != K_ILL) begin
      e = blank(3'd2);
      e.alusrc = (k == K_ALUI || k == K_LW || k == K_SW);
      e.aluop  = aop;
      if (k == K_BEQ && z) begin e.pcwe = 1'b1; e.pcsrc = 2'd1; end
      push({nm, ".exec"}, e, 1'b1);
    end
    if (k == K_LW || k == K_SW) begin
      e = blank(3'd3); e.req = 1'b1; e.iord = 1'b1; e.wr = (k == K_SW);
      for (int i = 0; i < mwait; i++) push({nm, ".memwait"}, e, 1'b0);
      e.mdrwe = (k == K_LW);
      push({nm, ".mem"}, e, 1'b1);
    end
    if (k == K_R || k == K_ALUI || k == K_LW) begin
      e = blank(3'd4); e.regwe = 1'b1; e.regdst = (k == K_R); e.m2r = (k == K_LW);
      push({nm, ".wb"}, e, 1'b1);
    end
    step_all();
    if (k != K_ILL) cnt = cnt + 1'b1;
  endtask

  // Monitor: compares every cycle for which an expectation is queued.
  always @(negedge clk) begin
    exp_t  e, a;
    string nm;
    if (expq.size() > 0) begin
      e  = expq.pop_front();
      nm = nameq.pop_front();
      a  = {state, mem_req, mem_wr, iord, ir_we, mdr_we, pc_we, pc_src,
            reg_we, reg_dst, mem_to_reg, alu_src, alu_op, ext_arith,
            illegal, retired};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s got=%h want=%h (st %0d/%0d ret %0d/%0d)",
                 nm, a, e, a.st, e.st, a.ret, e.ret);
      end
    end
  end

  initial begin
    exp_t e;
    rst = 1'b1; op = 6'h00; funct = 6'h00; zero = 1'b0; mem_ack = 1'b1;
    cnt = '0; cur_ext = 1'b0;
    @(posedge clk); #1;
    e = blank(3'd0);                  // in reset: FETCH, no request, count 0
    push("reset", e, 1'b1);
    step_all();
    rst = 1'b0;

    run_instr("add",   6'h00, 6'h20, K_R,    3'd0, 1'b0, 1'b0, 0, 0);
    run_instr("andi",  6'h0C, 6'h00, K_ALUI, 3'd2, 1'b0, 1'b0, 0, 0);
    run_instr("addi",  6'h08, 6'h00, K_ALUI, 3'd0, 1'b1, 1'b0, 0, 0);
    run_instr("lw",    6'h23, 6'h00, K_LW,   3'd0, 1'b1, 1'b0, 0, 3);
    run_instr("beq1",  6'h04, 6'h00, K_BEQ,  3'd1, 1'b1, 1'b1, 0, 0);
    run_instr("beq0",  6'h04, 6'h00, K_BEQ,  3'd1, 1'b1, 1'b0, 0, 0);
    run_instr("ill3f", 6'h3F, 6'h00, K_ILL,  3'd0, 1'b0, 1'b0, 0, 0);
    run_instr("illfn", 6'h00, 6'h21, K_ILL,  3'd0, 1'b0, 1'b0, 0, 0);
    run_instr("sub",   6'h00, 6'h22, K_R,    3'd1, 1'b0, 1'b0, 2, 0);
    run_instr("and",   6'h00, 6'h24, K_R,    3'd2, 1'b0, 1'b0, 0, 0);
    run_instr("or",    6'h00, 6'h25, K_R,    3'd3, 1'b0, 1'b0, 0, 0);
    run_instr("slt",   6'h00, 6'h2A, K_R,    3'd4, 1'b0, 1'b0, 0, 0);
    run_instr("addiu", 6'h09, 6'h00, K_ALUI, 3'd0, 1'b1, 1'b0, 0, 0);
    run_instr("slti",  6'h0A, 6'h00, K_ALUI, 3'd4, 1'b1, 1'b0, 0, 0);
    run_instr("ori",   6'h0D, 6'h00, K_ALUI, 3'd3, 1'b0, 1'b0, 0, 0);
    run_instr("sw",    6'h2B, 6'h00, K_SW,   3'd0, 1'b1, 1'b0, 0, 1);
    run_instr("j",     6'h02, 6'h00, K_J,    3'd0, 1'b0, 1'b0, 0, 0);
    // cnt is now all-ones: this LW retires and wraps the counter to 0.
    run_instr("lwwrap",6'h23, 6'h00, K_LW,   3'd0, 1'b1, 1'b0, 1, 0);
    run_instr("jpost", 6'h02, 6'h00, K_J,    3'd0, 1'b0, 1'b0, 0, 0);

    // SW interrupted by reset while waiting in MEM.
    op = 6'h2B; funct = 6'h00; zero = 1'b0; cur_ext = 1'b1;
    e = blank(3'd0); e.req = 1'b1; e.irwe = 1'b1; e.pcwe = 1'b1;
    push("swrst.fetch", e, 1'b1);
    e = blank(3'd1); push("swrst.decode", e, 1'b1);
    e = blank(3'd2); e.alusrc = 1'b1; push("swrst.exec", e, 1'b1);
    e = blank(3'd3); e.req = 1'b1; e.iord = 1'b1; e.wr = 1'b1;
    push("swrst.memwait", e, 1'b0);
    step_all();
    // Still in MEM here (ack was low); reset lands between clock edges.
    rst = 1'b1;
    cnt = '0;
    e = blank(3'd0);
    push("swrst.inreset", e, 1'b1);
    step_all();
    rst = 1'b0;
    run_instr("addpost", 6'h00, 6'h20, K_R, 3'd0, 1'b0, 1'b0, 0, 0);

    @(negedge clk); #1;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0 unchecked entries", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
